// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD display path.
package lcd_pkg;

  typedef logic [7:0] char_t;

  localparam char_t ASCII_SPACE = 8'h20;
  localparam char_t ASCII_ZERO  = 8'h30;
  localparam char_t ASCII_A     = 8'h41;

  localparam int unsigned LCD_LINE_CHARS = 16;

endpackage

// File: rtl/lcd_line_buffer_if.sv
// Slot read bus between the line buffer and the LCD string stage.
// master: the LCD stage, which drives rd_index.
// slave: the line buffer, which returns rd_data one cycle later.
interface lcd_line_buffer_if;
  import lcd_pkg::*;

  logic [4:0] rd_index;
  char_t      rd_data;

  modport master (output rd_index, input  rd_data);
  modport slave  (input  rd_index, output rd_data);

endinterface

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, press edge.
// Reusable for any active-low board key.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic iCLK_50MHZ,
  input  logic iRST_N,
  input  logic key_n,
  output logic level,
  output logic press_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          key_s;
  logic [CW-1:0] cnt;

  assign key_s = sync[1];

  // Bring the asynchronous key into the clock domain; idle level is released.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) sync <= '1;
    else         sync <= {sync[0], key_n};
  end

  // Accept a new level only after it has held for DEBOUNCE_CYCLES; strobe on press.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      level       <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (key_s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level       <= key_s;
        cnt         <= '0;
        press_pulse <= ~key_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_line_buffer.sv
// LCD line-2 character buffer: each debounced key press stores din in the
// next slot; the LCD stage reads slots by index over rd_bus.
// Build option LCD_LINE_BUFFER_SCROLL_EN: when full, a press scrolls the
// line left and appends at the right; otherwise pushes wrap and overwrite.
module lcd_line_buffer
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH           = LCD_LINE_CHARS,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter char_t       BLANK_CHAR      = ASCII_SPACE
) (
  input  logic                       iCLK_50MHZ,
  input  logic                       iRST_N,
  input  logic                       key_n,
  input  char_t                      din,
  input  logic                       clr,
  lcd_line_buffer_if.slave           rd_bus,
  output logic                       key_pulse,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       full
);

  localparam int unsigned    PW        = $clog2(DEPTH);
  localparam logic [PW-1:0]  LAST_SLOT = PW'(DEPTH - 1);
  localparam logic [PW:0]    FILL_MAX  = (PW + 1)'(DEPTH);

  char_t            mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             key_level;
  logic             push;
  logic [PW-1:0]    rd_slot;
  logic             rd_hit;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .iCLK_50MHZ (iCLK_50MHZ),
    .iRST_N     (iRST_N),
    .key_n      (key_n),
    .level      (key_level),
    .press_pulse(key_pulse)
  );

  // The debounced level is already low during the strobe; clr drops the push.
  assign push    = key_pulse & ~key_level & ~clr;
  assign full    = (fill == FILL_MAX);
  assign rd_slot = rd_bus.rd_index[PW-1:0];
  assign rd_hit  = (32'(rd_bus.rd_index) < DEPTH) && valid[rd_slot];

  // Character storage; contents are masked by valid so no reset is needed.
  always_ff @(posedge iCLK_50MHZ) begin
    if (push) begin
`ifdef LCD_LINE_BUFFER_SCROLL_EN
      if (full) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) mem[PW'(i)] <= mem[PW'(i + 1)];
        mem[LAST_SLOT] <= din;
      end else begin
        mem[wr_ptr] <= din;
      end
`else
      mem[wr_ptr] <= din;
`endif
    end
  end

  // Slot bookkeeping: valid bits, write pointer and fill level.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      valid  <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (clr) begin
      valid  <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (push) begin
      valid[wr_ptr] <= 1'b1;
      if (!full) fill <= fill + 1'b1;
`ifdef LCD_LINE_BUFFER_SCROLL_EN
      if (wr_ptr != LAST_SLOT) wr_ptr <= wr_ptr + 1'b1;
`else
      wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
`endif
    end
  end

  // Registered read: blank for empty or out-of-range slots.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) rd_bus.rd_data <= BLANK_CHAR;
    else         rd_bus.rd_data <= rd_hit ? mem[rd_slot] : BLANK_CHAR;
  end

endmodule
